// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush sequencer with saturating bubble counter
module pipe_hazard_ctrl #(
   parameter int STALL_CYCLES = 2,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             hazard,
   input  logic             br_taken,
   input  logic             clr_cnt,
   output logic             pc_hold,
   output logic             ifdof_hold,
   output logic             dofex_bubble,
   output logic             ifdof_flush,
   output logic             dofex_flush,
   output logic             busy,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_total
);

   typedef enum logic [1:0] {
      RUN     = 2'b00,
      STALL   = 2'b01,
      FLUSH   = 2'b10,
      ILLEGAL = 2'b11
   } state_t;

   // Counter reload values; the entry cycle is already one of the counted cycles.
   localparam logic [3:0] STALL_LOAD = 4'(STALL_CYCLES - 1);
   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
   localparam state_t     STALL_NEXT = (STALL_CYCLES > 1) ? STALL : RUN;
   localparam state_t     FLUSH_NEXT = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       hold_c, flush_c;

   // State and remaining-cycle counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and raw control decode; a taken branch always wins over a hazard.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold_c  = 1'b0;
      flush_c = 1'b0;
      case (state_q)
         RUN: begin
            if (br_taken) begin
               flush_c = 1'b1;
               cnt_d   = FLUSH_LOAD;
               state_d = FLUSH_NEXT;
            end else if (hazard) begin
               hold_c  = 1'b1;
               cnt_d   = STALL_LOAD;
               state_d = STALL_NEXT;
            end
         end
         STALL: begin
            if (br_taken) begin
               flush_c = 1'b1;
               cnt_d   = FLUSH_LOAD;
               state_d = FLUSH_NEXT;
            end else begin
               hold_c = 1'b1;
               cnt_d  = cnt_q - 4'd1;
               if (cnt_q <= 4'd1) begin
                  state_d = RUN;
               end
            end
         end
         FLUSH: begin
            flush_c = 1'b1;
            cnt_d   = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = RUN;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Outputs are forced low for the whole time reset is asserted.
   assign pc_hold      = rst_n & hold_c;
   assign ifdof_hold   = rst_n & hold_c;
   assign dofex_bubble = rst_n & hold_c;
   assign ifdof_flush  = rst_n & flush_c;
   assign dofex_flush  = rst_n & flush_c;
   assign busy         = rst_n & (state_q != RUN);
   assign state        = rst_n ? state_q : 2'b00;

   // Saturating bubble-cycle counter; clear beats increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_total <= '0;
      end else if (clr_cnt) begin
         stall_total <= '0;
      end else if (dofex_bubble && (stall_total != {CNT_W{1'b1}})) begin
         stall_total <= stall_total + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - randomized reference-model bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

   logic clk = 1'b0;
   logic rst_n, hazard, br_taken, clr_cnt;
   logic [2:0] pc_hold, ifdof_hold, dofex_bubble, ifdof_flush, dofex_flush, busy;
   logic [1:0] st0, st1, st2;
   logic [15:0] tot0, tot2;
   logic [3:0]  tot1;

   int total = 0;
   int bad   = 0;

   // Per-instance configuration: defaults, longer episodes with narrow counter, single-cycle.
   int SC[3]  = '{2, 3, 1};
   int FC[3]  = '{2, 4, 1};
   int MAXC[3] = '{65535, 15, 65535};

   // Reference model: cycles still owed to the current stall / flush episode, bubble tally.
   int s_left[3];
   int f_left[3];
   int tot_m[3];

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.STALL_CYCLES(2), .FLUSH_CYCLES(2), .CNT_W(16)) u0 (
      .clk(clk), .rst_n(rst_n), .hazard(hazard), .br_taken(br_taken), .clr_cnt(clr_cnt),
      .pc_hold(pc_hold[0]), .ifdof_hold(ifdof_hold[0]), .dofex_bubble(dofex_bubble[0]),
      .ifdof_flush(ifdof_flush[0]), .dofex_flush(dofex_flush[0]), .busy(busy[0]),
      .state(st0), .stall_total(tot0));

   pipe_hazard_ctrl #(.STALL_CYCLES(3), .FLUSH_CYCLES(4), .CNT_W(4)) u1 (
      .clk(clk), .rst_n(rst_n), .hazard(hazard), .br_taken(br_taken), .clr_cnt(clr_cnt),
      .pc_hold(pc_hold[1]), .ifdof_hold(ifdof_hold[1]), .dofex_bubble(dofex_bubble[1]),
      .ifdof_flush(ifdof_flush[1]), .dofex_flush(dofex_flush[1]), .busy(busy[1]),
      .state(st1), .stall_total(tot1));

   pipe_hazard_ctrl #(.STALL_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(16)) u2 (
      .clk(clk), .rst_n(rst_n), .hazard(hazard), .br_taken(br_taken), .clr_cnt(clr_cnt),
      .pc_hold(pc_hold[2]), .ifdof_hold(ifdof_hold[2]), .dofex_bubble(dofex_bubble[2]),
      .ifdof_flush(ifdof_flush[2]), .dofex_flush(dofex_flush[2]), .busy(busy[2]),
      .state(st2), .stall_total(tot2));

   // Packed control view: {pc_hold, ifdof_hold, dofex_bubble, ifdof_flush, dofex_flush, busy, state}
   function automatic logic [7:0] obs(input int i);
      logic [1:0] s;
      case (i)
         0:       s = st0;
         1:       s = st1;
         default: s = st2;
      endcase
      return {pc_hold[i], ifdof_hold[i], dofex_bubble[i], ifdof_flush[i], dofex_flush[i],
              busy[i], s};
   endfunction

   function automatic logic [31:0] tot_obs(input int i);
      case (i)
         0:       return {16'd0, tot0};
         1:       return {28'd0, tot1};
         default: return {16'd0, tot2};
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         s_left[i] = 0;
         f_left[i] = 0;
         tot_m[i]  = 0;
      end
   endtask

   // Expected controls for this cycle plus the episode bookkeeping after the edge.
   task automatic model_eval(input int i, input logic h, input logic b,
                             output logic [7:0] ev, output int ns, output int nf);
      logic hold, fl;
      logic [1:0] st;
      hold = 1'b0;
      fl   = 1'b0;
      ns   = s_left[i];
      nf   = f_left[i];
      st   = (f_left[i] > 0) ? 2'd2 : (s_left[i] > 0) ? 2'd1 : 2'd0;
      if (f_left[i] > 0) begin
         fl = 1'b1;
         nf = f_left[i] - 1;
      end else if (b) begin
         fl = 1'b1;
         ns = 0;
         nf = FC[i] - 1;
      end else if (s_left[i] > 0) begin
         hold = 1'b1;
         ns = s_left[i] - 1;
      end else if (h) begin
         hold = 1'b1;
         ns = SC[i] - 1;
      end
      ev = {hold, hold, hold, fl, fl, (st != 2'd0), st};
   endtask

   task automatic cycle(input logic h, input logic b, input logic c);
      logic [7:0] ev;
      int ns[3];
      int nf[3];
      int nt[3];
      hazard   = h;
      br_taken = b;
      clr_cnt  = c;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         model_eval(i, h, b, ev, ns[i], nf[i]);
         check($sformatf("ctl%0d h%0d b%0d", i, h, b), {24'd0, obs(i)}, {24'd0, ev});
         check($sformatf("total%0d", i), tot_obs(i), tot_m[i]);
         if (c)
            nt[i] = 0;
         else if (ev[5])
            nt[i] = (tot_m[i] >= MAXC[i]) ? MAXC[i] : tot_m[i] + 1;
         else
            nt[i] = tot_m[i];
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         s_left[i] = ns[i];
         f_left[i] = nf[i];
         tot_m[i]  = nt[i];
      end
   endtask

   task automatic check_all_zero(input string tag);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("%s_ctl%0d", tag, i), {24'd0, obs(i)}, 32'd0);
         check($sformatf("%s_total%0d", tag, i), tot_obs(i), 32'd0);
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      hazard   = 1'b1;
      br_taken = 1'b1;
      clr_cnt  = 1'b0;
      model_reset();
      #12;
      check_all_zero("reset");
      hazard   = 1'b0;
      br_taken = 1'b0;
      rst_n    = 1'b1;
      @(posedge clk);
      #1;

      // Single-cycle hazard.
      cycle(1, 0, 0);
      for (int k = 0; k < 4; k++) cycle(0, 0, 0);
      check("t2_total_u0", tot_obs(0), 32'd2);

      // Hazard and branch together: branch wins.
      cycle(1, 1, 0);
      for (int k = 0; k < 4; k++) cycle(0, 0, 0);
      check("t3_total_u0", tot_obs(0), 32'd2);

      // Branch aborts a stall in progress.
      cycle(1, 0, 0);
      cycle(0, 1, 0);
      for (int k = 0; k < 5; k++) cycle(0, 0, 0);
      check("t4_total_u0", tot_obs(0), 32'd3);

      // Long hazard: continuous bubbles and saturation of the narrow counter.
      for (int k = 0; k < 20; k++) cycle(1, 0, 0);
      check("t5_sat_u1", tot_obs(1), 32'd15);
      cycle(1, 0, 1);
      check("t5_clr_u1", tot_obs(1), 32'd0);
      for (int k = 0; k < 4; k++) cycle(0, 0, 0);

      // Reset asserted in the middle of a stall.
      cycle(1, 0, 0);
      hazard = 1'b1;
      rst_n  = 1'b0;
      #1;
      check_all_zero("midrst");
      model_reset();
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      hazard = 1'b0;
      cycle(0, 0, 0);

      // Randomized traffic.
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 99) == 0) begin
            rst_n = 1'b0;
            #1;
            check_all_zero("rndrst");
            model_reset();
            @(posedge clk);
            #1;
            rst_n = 1'b1;
         end
         cycle($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 15,
               $urandom_range(0, 99) < 3);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
